famicom_bus_master: RTL and testbench

//  Initiator for the cartridge CPU/PPU buses: turns a valid/ready request stream into

---
 rtl/famicom_bus_pkg.sv | 17 +
 rtl/famicom_bus_m2_phase_gen.sv | 39 +++
 rtl/famicom_bus_master.sv | 176 +++++++++++++++++
 tb/tb_famicom_bus_master.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/famicom_bus_pkg.sv
// Shared types and constants for the Famicom cartridge bus master.
package famicom_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        C_LOW,
        C_HIGH,
        P_SETUP,
        P_STROBE,
        P_HOLD
    } bus_state_e;

    localparam int ROMSEL_A15     = 15;
    localparam int M2_DIV_DEF     = 12;
    localparam int PPU_STROBE_DEF = 4;

endpackage

// File: rtl/famicom_bus_m2_phase_gen.sv
// Free-running m2 (phi2) generator: low for the first half of the period, high for the second.
module m2_phase_gen #(
    parameter  int M2_DIV = 12,
    localparam int CW     = $clog2(M2_DIV)
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic [CW-1:0] cnt_o,
    output logic          m2_o,
    output logic          last_clk_o
);

    localparam logic [CW-1:0] LAST = CW'(M2_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(M2_DIV / 2);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          m2_q, m2_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        // m2 is registered from the next count so it is glitch-free and aligned to cnt
        m2_d  = (cnt_d >= HALF);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
            m2_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            m2_q  <= m2_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign m2_o       = m2_q;
    assign last_clk_o = (cnt_q == LAST);

endmodule

// File: rtl/famicom_bus_master.sv
// Turns a valid/ready request stream into Famicom CPU/PPU cartridge bus cycles.
module famicom_bus_master
    import famicom_bus_pkg::*;
#(
    parameter int M2_DIV     = M2_DIV_DEF,
    parameter int PPU_STROBE = PPU_STROBE_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_ppu,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        m2,
    output logic        romsel,
    output logic        cpu_rw,
    output logic [14:0] cpu_addr,
    output logic [7:0]  cpu_data_o,
    output logic        cpu_data_oe,
    input  logic [7:0]  cpu_data_i,
    output logic        ppu_rd,
    output logic        ppu_wr,
    output logic [13:0] ppu_addr,
    output logic [7:0]  ppu_data_o,
    output logic        ppu_data_oe,
    input  logic [7:0]  ppu_data_i,
    input  logic        irq_n,
    output logic        irq_level
);

    localparam int CW = $clog2(M2_DIV);
    localparam int SW = (PPU_STROBE > 1) ? $clog2(PPU_STROBE) : 1;
    localparam logic [CW-1:0] HALF_M1  = CW'(M2_DIV / 2 - 1);
    localparam logic [SW-1:0] STB_LAST = SW'(PPU_STROBE - 1);

    bus_state_e    state_q, state_d;
    logic [CW-1:0] cnt;
    logic          m2_w;
    logic          last_clk;
    logic [SW-1:0] scnt_q, scnt_d;
    logic          wr_q, wr_d;
    logic          a15_q, a15_d;
    logic [14:0]   cpu_addr_q, cpu_addr_d;
    logic [13:0]   ppu_addr_q, ppu_addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          irq_s1_q, irq_lvl_q;
    logic          cpu_slot;
    logic          accept;

    m2_phase_gen #(
        .M2_DIV     (M2_DIV)
    ) u_phase (
        .clk        (clk),
        .reset_n    (reset_n),
        .cnt_o      (cnt),
        .m2_o       (m2_w),
        .last_clk_o (last_clk)
    );

    // The read-sample clk of a CPU cycle doubles as the next CPU accept slot
    assign cpu_slot  = last_clk & ((state_q == IDLE) | (state_q == C_HIGH));
    assign req_ready = req_is_ppu ? (state_q == IDLE) : cpu_slot;
    assign accept    = req_valid & req_ready;

    always_comb begin
        state_d     = state_q;
        scnt_d      = scnt_q;
        wr_d        = wr_q;
        a15_d       = a15_q;
        cpu_addr_d  = cpu_addr_q;
        ppu_addr_d  = ppu_addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rdata_d     = 8'h00;

        if (accept) begin
            wr_d    = req_write;
            wdata_d = req_wdata;
            if (req_is_ppu) begin
                ppu_addr_d = req_addr[13:0];
            end else begin
                cpu_addr_d = req_addr[14:0];
                a15_d      = req_addr[ROMSEL_A15];
            end
        end

        unique case (state_q)
            IDLE: begin
                if (accept) state_d = req_is_ppu ? P_SETUP : C_LOW;
            end
            C_LOW: begin
                if (cnt == HALF_M1) state_d = C_HIGH;
            end
            C_HIGH: begin
                if (last_clk) begin
                    rsp_valid_d = 1'b1;
                    rdata_d     = wr_q ? 8'h00 : cpu_data_i;
                    state_d     = accept ? C_LOW : IDLE;
                end
            end
            P_SETUP: begin
                scnt_d  = '0;
                state_d = P_STROBE;
            end
            P_STROBE: begin
                if (scnt_q == STB_LAST) begin
                    rsp_valid_d = 1'b1;
                    rdata_d     = wr_q ? 8'h00 : ppu_data_i;
                    state_d     = P_HOLD;
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
            P_HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            scnt_q      <= '0;
            wr_q        <= 1'b0;
            a15_q       <= 1'b0;
            cpu_addr_q  <= '0;
            ppu_addr_q  <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            irq_s1_q    <= 1'b0;
            irq_lvl_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            scnt_q      <= scnt_d;
            wr_q        <= wr_d;
            a15_q       <= a15_d;
            cpu_addr_q  <= cpu_addr_d;
            ppu_addr_q  <= ppu_addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            irq_s1_q    <= ~irq_n;
            irq_lvl_q   <= irq_s1_q;
        end
    end

    assign m2          = m2_w;
    // Idle periods keep decoding the last A15, like the CPU's dummy reads
    assign romsel      = ~(a15_q & m2_w);
    assign cpu_rw      = ~(wr_q & ((state_q == C_LOW) | (state_q == C_HIGH)));
    assign cpu_addr    = cpu_addr_q;
    assign cpu_data_o  = wdata_q;
    assign cpu_data_oe = wr_q & (state_q == C_HIGH);

    assign ppu_rd      = ~(~wr_q & (state_q == P_STROBE));
    assign ppu_wr      = ~(wr_q & (state_q == P_STROBE));
    assign ppu_addr    = ppu_addr_q;
    assign ppu_data_o  = wdata_q;
    assign ppu_data_oe = wr_q & ((state_q == P_SETUP) | (state_q == P_STROBE)
                                 | (state_q == P_HOLD));

    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rdata_q;
    assign irq_level   = irq_lvl_q;

endmodule

// File: tb/tb_famicom_bus_master.sv
// Directed bench for famicom_bus_master: m2 timing, CPU/PPU cycles, reset abort, IRQ sync.
module tb_famicom_bus_master;

    localparam int M2_DIV     = 12;
    localparam int PPU_STROBE = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_ppu = 1'b0;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        m2, romsel, cpu_rw;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_data_o;
    logic        cpu_data_oe;
    logic [7:0]  cpu_data_i = '0;
    logic        ppu_rd, ppu_wr;
    logic [13:0] ppu_addr;
    logic [7:0]  ppu_data_o;
    logic        ppu_data_oe;
    logic [7:0]  ppu_data_i = '0;
    logic        irq_n = 1'b1;
    logic        irq_level;

    int n_vec = 0;
    int n_err = 0;
    int ph = 0;
    bit last_a15 = 1'b0;

    famicom_bus_master #(
        .M2_DIV      (M2_DIV),
        .PPU_STROBE  (PPU_STROBE)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_is_ppu  (req_is_ppu),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .m2          (m2),
        .romsel      (romsel),
        .cpu_rw      (cpu_rw),
        .cpu_addr    (cpu_addr),
        .cpu_data_o  (cpu_data_o),
        .cpu_data_oe (cpu_data_oe),
        .cpu_data_i  (cpu_data_i),
        .ppu_rd      (ppu_rd),
        .ppu_wr      (ppu_wr),
        .ppu_addr    (ppu_addr),
        .ppu_data_o  (ppu_data_o),
        .ppu_data_oe (ppu_data_oe),
        .ppu_data_i  (ppu_data_i),
        .irq_n       (irq_n),
        .irq_level   (irq_level)
    );

    always #5 clk = ~clk;

    // Reference m2 phase: 0..M2_DIV-1, cleared by reset
    always @(posedge clk) begin
        if (!reset_n) ph <= 0;
        else          ph <= (ph == M2_DIV - 1) ? 0 : ph + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".m2"},      m2, 0);
        check({tag, ".romsel"},  romsel, 1);
        check({tag, ".cpu_rw"},  cpu_rw, 1);
        check({tag, ".caddr"},   cpu_addr, 0);
        check({tag, ".coe"},     cpu_data_oe, 0);
        check({tag, ".ppu_rd"},  ppu_rd, 1);
        check({tag, ".ppu_wr"},  ppu_wr, 1);
        check({tag, ".paddr"},   ppu_addr, 0);
        check({tag, ".poe"},     ppu_data_oe, 0);
        check({tag, ".ready"},   req_ready, 0);
        check({tag, ".rsp"},     rsp_valid, 0);
        check({tag, ".rdata"},   rsp_rdata, 0);
        check({tag, ".irq"},     irq_level, 0);
    endtask

    // One full transaction with per-clk expectations for both buses
    task automatic xfer(input bit ppu, input bit wr, input logic [15:0] a,
                        input logic [7:0] wd, input logic [7:0] bus,
                        input string tag);
        int  w, lat, b_m2, b_rom, b_cpu, b_ppu, b_rdy;
        bit  seen, act, stb, m2e;
        logic [7:0] rd;
        req_valid  = 1'b1;
        req_is_ppu = ppu;
        req_write  = wr;
        req_addr   = a;
        req_wdata  = wd;
        cpu_data_i = bus;
        ppu_data_i = bus;
        w = 0;
        while (!req_ready && w < 40) begin
            step();
            w++;
        end
        check({tag, ".rdy"}, req_ready, 1);
        if (!ppu) check({tag, ".slot"}, ph, M2_DIV - 1);
        step();
        req_valid = 1'b0;
        req_addr  = ~a;
        req_write = ~wr;
        req_wdata = ~wd;
        if (!ppu) last_a15 = a[15];
        lat = 1; seen = 0; rd = 0;
        b_m2 = 0; b_rom = 0; b_cpu = 0; b_ppu = 0; b_rdy = 0;
        while (!seen && lat < 30) begin
            m2e = (ph >= M2_DIV / 2);
            if (m2 !== m2e) b_m2++;
            if (romsel !== ~(last_a15 & m2e)) b_rom++;
            if (ppu) begin
                act = (lat <= PPU_STROBE + 2);
                stb = (lat >= 2) && (lat <= PPU_STROBE + 1);
                if (cpu_rw !== 1'b1 || cpu_data_oe !== 1'b0) b_cpu++;
                if (ppu_rd !== !(stb && !wr)) b_ppu++;
                if (ppu_wr !== !(stb && wr)) b_ppu++;
                if (ppu_data_oe !== (wr && act)) b_ppu++;
                if (act && ppu_addr !== a[13:0]) b_ppu++;
                if (act && wr && ppu_data_o !== wd) b_ppu++;
                if (req_ready !== 1'b0) b_rdy++;
            end else begin
                act = (lat <= M2_DIV);
                if (cpu_rw !== !(act && wr)) b_cpu++;
                if (cpu_data_oe !== (act && wr && m2e)) b_cpu++;
                if (act && cpu_addr !== a[14:0]) b_cpu++;
                if (act && wr && cpu_data_o !== wd) b_cpu++;
                if (ppu_rd !== 1'b1 || ppu_wr !== 1'b1 || ppu_data_oe !== 1'b0) b_ppu++;
                if (req_ready !== (lat == M2_DIV)) b_rdy++;
            end
            if (rsp_valid === 1'b1) begin
                seen = 1;
                rd = rsp_rdata;
            end else begin
                step();
                lat++;
            end
        end
        check({tag, ".lat"}, lat, ppu ? PPU_STROBE + 2 : M2_DIV + 1);
        check({tag, ".rdata"}, rd, wr ? 8'h00 : bus);
        check({tag, ".m2"}, b_m2, 0);
        check({tag, ".romsel"}, b_rom, 0);
        check({tag, ".cpubus"}, b_cpu, 0);
        check({tag, ".ppubus"}, b_ppu, 0);
        check({tag, ".ready"}, b_rdy, 0);
    endtask

    initial begin : main
        int hi, rise, b_m2, b_rom, b_rw, b_rsp;
        bit prev;

        // 1: reset, then three idle m2 periods
        repeat (3) step();
        check_reset("t1");
        reset_n = 1'b1;
        hi = 0; rise = 0; b_m2 = 0; b_rom = 0; b_rw = 0; b_rsp = 0;
        prev = m2;
        for (int i = 0; i < 3 * M2_DIV; i++) begin
            step();
            if (m2 !== (ph >= M2_DIV / 2)) b_m2++;
            if (m2 === 1'b1) hi++;
            if (m2 === 1'b1 && !prev) rise++;
            prev = m2;
            if (romsel !== 1'b1) b_rom++;
            if (cpu_rw !== 1'b1) b_rw++;
            if (rsp_valid !== 1'b0) b_rsp++;
        end
        check("t1.m2_phase", b_m2, 0);
        check("t1.m2_high", hi, 3 * M2_DIV / 2);
        check("t1.m2_rise", rise, 3);
        check("t1.romsel", b_rom, 0);
        check("t1.cpu_rw", b_rw, 0);
        check("t1.no_rsp", b_rsp, 0);

        // 2..4: single CPU read, CPU write, PPU read
        xfer(1'b0, 1'b0, 16'h8000, 8'h00, 8'hA5, "t2");
        xfer(1'b0, 1'b1, 16'h6000, 8'h3C, 8'hFF, "t3");
        xfer(1'b1, 1'b0, 16'h1FF0, 8'h00, 8'h77, "t4");

        // 5: queued CPU write, PPU write (A15:14 ignored), CPU read
        xfer(1'b0, 1'b1, 16'hA001, 8'h5A, 8'h00, "t5a");
        xfer(1'b1, 1'b1, 16'hE123, 8'hC3, 8'h00, "t5b");
        xfer(1'b0, 1'b0, 16'hFFFC, 8'h00, 8'h12, "t5c");

        // 6: reset in the m2-high half of a $C000 read, then IRQ sync
        req_valid  = 1'b1;
        req_is_ppu = 1'b0;
        req_write  = 1'b0;
        req_addr   = 16'hC000;
        cpu_data_i = 8'h99;
        for (int i = 0; i < 40 && !req_ready; i++) step();
        check("t6.rdy", req_ready, 1);
        step();
        req_valid = 1'b0;
        repeat (7) step();
        check("t6.mid_m2", m2, 1);
        check("t6.mid_romsel", romsel, 0);
        reset_n = 1'b0;
        step();
        check_reset("t6");
        last_a15 = 1'b0;
        step();
        reset_n = 1'b1;
        b_m2 = 0; b_rom = 0; b_rsp = 0;
        for (int i = 0; i < 2 * M2_DIV; i++) begin
            step();
            if (m2 !== (ph >= M2_DIV / 2)) b_m2++;
            if (romsel !== 1'b1) b_rom++;
            if (rsp_valid !== 1'b0) b_rsp++;
        end
        check("t6.post_m2", b_m2, 0);
        check("t6.post_romsel", b_rom, 0);
        check("t6.no_rsp", b_rsp, 0);
        irq_n = 1'b0;
        step();
        check("t6.irq_1clk", irq_level, 0);
        step();
        check("t6.irq_2clk", irq_level, 1);
        irq_n = 1'b1;
        step();
        check("t6.irq_hold", irq_level, 1);
        step();
        check("t6.irq_clear", irq_level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
